serial_adder: RTL
=================

# serial_adder

Bit-serial WIDTH-bit adder controller that drives the team's 1-bit full adder cell, one bit per clock, LSB first. It latches two operands and a carry-in on a start pulse and presents one operand bit pair plus the running carry to the full adder each cycle. It collects the sum bit and carry-out back into a result register. The block sits directly upstream and downstream of the full adder cell: it feeds the cell's inputs and consumes its outputs, and the cell is instantiated beside it and wired to the `fa_*` ports.

## Interface
- WIDTH, 8, operand and sum width in bits (>= 2)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- c_in  input  1  carry-in, sampled on accepted start
- fa_a  output  1  current A bit to full adder (combinational from operand shift reg LSB)
- fa_b  output  1  current B bit to full adder
- fa_cin  output  1  running carry to full adder (carry register)
- fa_y  input  1  sum bit from full adder
- fa_cout  input  1  carry-out from full adder
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when result valid
- sum  output  WIDTH  registered result, held until next completion
- c_out  output  1  registered final carry, held with sum

## Operation
- One clock domain, one synchronous active-low reset: clk, rst_n.
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle.
  - DONE: lasts one cycle, then returns to IDLE.
- Transitions:
  - IDLE & start -> RUN.
  - RUN & bit count == WIDTH-1 -> DONE.
  - DONE -> IDLE unconditionally.
- On the accepted start edge:
  - opA <= a, opB <= b, carry <= c_in, count <= 0, result shift reg <= 0.
- Each RUN edge:
  - result <= {fa_y, result[WIDTH-1:1]}, carry <= fa_cout.
  - opA, opB shift right by 1 with 0 fill; count++.
- Entering DONE:
  - sum <= final assembled result, including the bit captured on that edge.
  - c_out <= fa_cout.
- Arithmetic: {c_out, sum} = a + b + c_in, modulo 2^(WIDTH+1); no overflow flag.
- start in RUN or DONE is ignored and not queued.
- fa_a/fa_b/fa_cin are don't-care outside RUN but must be driven (no X) after reset; sum/c_out are unaffected by the `fa_*` inputs outside RUN.
- Reset:
  - State -> IDLE; busy=0, done=0, sum=0, c_out=0, fa_a=fa_b=fa_cin=0.
  - All internal registers are 0.
  - Reset asserted mid-RUN aborts the operation: no done pulse, and sum/c_out are cleared to 0.

## Timing
- The start edge is edge k. RUN occupies the cycles after edges k..k+WIDTH-1 (busy high for WIDTH cycles).
- Edge k+WIDTH enters DONE; done is high for exactly one cycle after it, with sum/c_out valid in that same cycle.
- Latency from start edge to done high: WIDTH+1 edges.
- Next start is accepted at the earliest on the edge that ends DONE+1, i.e. the first IDLE cycle. Minimum issue interval is WIDTH+2 cycles.
- The full adder path (`fa_*` out -> cell -> `fa_*` in) is combinational and must settle within one clock period.
- start held high continuously produces back-to-back operations every WIDTH+2 cycles.

## Test plan
- Reset with rst_n=0 for 2 cycles, all inputs random -> busy=0, done=0, sum=0x00, c_out=0, fa_* = 0.
- WIDTH=8: a=0x5A, b=0x33, c_in=0, start pulse -> busy for 8 cycles; done 9 cycles after the start edge with sum=0x8D, c_out=0.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
- Start pulse with a=0x10, b=0x01 while busy from a prior 0x0F+0x01 operation -> only one done, with sum=0x10, c_out=0; the second request is ignored.
- rst_n low for 1 cycle at the 4th RUN cycle -> no done pulse; sum=0, c_out=0, IDLE. A fresh start with 0x01+0x01 then yields sum=0x02.
- Random self-check: 1000 random a/b/c_in triples against the reference a+b+c_in -> {c_out,sum} matches every operation; done count equals start-accepted count.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder controller: feeds an external 1-bit full adder cell one
// bit pair per clock (LSB first) and assembles the sum and final carry it returns.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_y,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               opa_d   = a;
               opb_d   = b;
               carry_d = c_in;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         StRun: begin
            // Sum bits enter at the MSB so the LSB-first stream lands in place.
            res_d   = {fa_y, res_q[WIDTH-1:1]};
            carry_d = fa_cout;
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = StDone;
               sum_d   = res_d;
               cout_d  = fa_cout;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign fa_a   = opa_q[0];
   assign fa_b   = opb_q[0];
   assign fa_cin = carry_q;
   assign busy   = (state_q == StRun);
   assign done   = (state_q == StDone);
   assign sum    = sum_q;
   assign c_out  = cout_q;

endmodule
